mips_bus_arbiter: RTL
=====================

# mips_bus_arbiter

Two-master, one-slave arbiter for the Avalon memory-mapped bus used by the MIPS CPU. It lets the instruction-fetch port (M0) and the data port (M1), or the CPU and a test/DMA master, share a single memory slave. It grants at most one single-word transfer at a time and alternates fairly between the masters. It also flags slaves that stall for too long.

## Interface
Parameters:
- TIMEOUT, 1024: consecutive stalled cycles of a granted transfer before `timeout_err` sets. 0 disables the watchdog.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- m0_address / m1_address  in  32  master byte address
- m0_read / m1_read  in  1  read request, held until that master's waitrequest is low
- m0_write / m1_write  in  1  write request, held likewise
- m0_writedata / m1_writedata  in  32  write data
- m0_byteenable / m1_byteenable  in  4  byte lanes
- m0_waitrequest / m1_waitrequest  out  1  stall to master
- m0_readdata / m1_readdata  out  32  read data, valid when the master's waitrequest is low
- s_address  out  32  slave address
- s_read, s_write  out  1  slave request
- s_writedata  out  32  slave write data
- s_byteenable  out  4  slave byte lanes
- s_waitrequest  in  1  slave stall
- s_readdata  in  32  slave read data
- grant  out  2  one-hot current grant; 2'b00 when idle
- timeout_err  out  1  sticky watchdog flag
- proto_err  out  1  sticky flag: a master asserted read and write in the same cycle

## Operation
- Request: reqX = mX_read | mX_write.
- States:
  - IDLE: `grant` = 00.
  - GNT0: `grant` = 01.
  - GNT1: `grant` = 10.
- Register `last`, reset value 1 (M1), records the most recently granted master.
- IDLE:
  - If only one master requests, that master is granted next cycle.
  - If both request, the master that is not `last` is granted.
  - If neither requests, stay in IDLE.
- GNTx:
  - Slave outputs are combinationally mux'd from Mx.
  - s_waitrequest is forwarded to mx_waitrequest.
  - Completion is the cycle where reqX=1 and s_waitrequest=0.
- On completion:
  - `last` is set to x.
  - If the other master requests in that cycle, go directly to GNT(other).
  - Otherwise go to IDLE. The completing master's request in the completion cycle belongs to the finished transfer and is ignored.
- GNTx with reqX=0 (master withdrew; illegal under Avalon): return to IDLE next cycle; no flag.
- Non-granted master: waitrequest=1 always.
- IDLE: m0_waitrequest = m1_waitrequest = 1.
- Slave outputs when idle: s_read = s_write = 0; s_address, s_writedata and s_byteenable are 0.
- Read data: s_readdata is broadcast to both mX_readdata.
- Read+write together on either master: proto_err sets. If granted, the transfer is forwarded unchanged.
- Watchdog:
  - A 32-bit stall counter increments each cycle in GNTx with s_waitrequest=1.
  - It clears on completion and in IDLE.
  - When the count reaches TIMEOUT, timeout_err sets.
  - No abort; the transfer continues.
- Sticky flags clear only on reset.

## Timing
- Reset:
  - State goes to IDLE, `last`=1, counter=0, both error flags=0.
  - While reset is high, s_read/s_write are forced to 0 and both waitrequests to 1 combinationally, including mid-transfer.
  - Reset mid-transfer abandons the transfer. The master must re-issue it after reset.
- Latency from IDLE: request first seen in cycle N; grant registered at edge N+1; slave sees the request in cycle N+1. With a zero-wait slave the master sees waitrequest=0 in N+1, so the minimum is 2 cycles per transfer.
- Handover with the other master pending: that master's first slave cycle is K+1 after completion cycle K, so there are no idle slave cycles between the masters.
- Same master back-to-back with the other master idle: IDLE in K+1, regrant at K+2; one bubble cycle.
- Simultaneous requests at reset exit: M0 wins first, because `last`=1.

## Test plan
- M0 reads 0xBFC00000 alone, zero-wait slave returning 0x12345678 → grant=01 in cycle N+1, m0_waitrequest low in N+1, m0_readdata=0x12345678, m1_waitrequest=1 throughout.
- M0 and M1 both request from reset exit, slave waitrequest low → order is M0, M1, M0, M1 with no idle slave cycles between grants; `grant` goes 01,10,01,10.
- M1 writes 0xDEADBEEF with byteenable 0011 to 0x100, slave stalls 3 cycles → s_* carries M1 values for 4 cycles and m1_waitrequest mirrors the stall. M0 requesting meanwhile sees waitrequest=1 and is granted in the cycle after completion.
- TIMEOUT=4, slave holds waitrequest for 10 cycles → timeout_err rises after the 4th stalled cycle and stays high after completion until reset.
- Reset asserted in the 2nd stalled cycle of an M1 write → s_write=0 in that same cycle, grant=00 after the edge, flags and `last` at reset values; a new M0 read after reset succeeds.
- M0 asserts read and write together → proto_err=1 from the next edge, sticky.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: two-master, one-slave Avalon-MM arbiter with fair alternation and stall watchdog
//   clk, reset                  : clock, synchronous active-high reset
//   m0_* / m1_*                 : master ports (address, read, write, writedata, byteenable in;
//                                 waitrequest, readdata out)
//   s_*                         : slave port (address, read, write, writedata, byteenable out;
//                                 waitrequest, readdata in)
//   grant                       : one-hot current owner, 00 when idle
//   timeout_err, proto_err      : sticky error flags, cleared only by reset
module mips_bus_arbiter #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   output logic [1:0]  grant,
   output logic        timeout_err,
   output logic        proto_err
);
   typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
   state_t      state;
   logic        last;
   logic [31:0] stall_cnt;
   logic        req0, req1, act0, act1, stall;
   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   // reset gates the slave request and master handshakes immediately, even mid-transfer
   assign act0 = (state == GNT0) && !reset;
   assign act1 = (state == GNT1) && !reset;
   assign stall = (state != IDLE) && s_waitrequest;
   assign grant = state;
   assign m0_readdata = s_readdata;
   assign m1_readdata = s_readdata;
   always_comb begin
      s_address      = act0 ? m0_address    : act1 ? m1_address    : 32'd0;
      s_read         = act0 ? m0_read       : act1 ? m1_read       : 1'b0;
      s_write        = act0 ? m0_write      : act1 ? m1_write      : 1'b0;
      s_writedata    = act0 ? m0_writedata  : act1 ? m1_writedata  : 32'd0;
      s_byteenable   = act0 ? m0_byteenable : act1 ? m1_byteenable : 4'd0;
      m0_waitrequest = !act0 || s_waitrequest;
      m1_waitrequest = !act1 || s_waitrequest;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last        <= 1'b1;
         stall_cnt   <= 32'd0;
         timeout_err <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         // saturate so a very long stall cannot wrap the count
         stall_cnt <= !stall ? 32'd0 : (stall_cnt == '1) ? stall_cnt : stall_cnt + 32'd1;
         if (TIMEOUT != 0 && stall && stall_cnt + 32'd1 >= TIMEOUT)
            timeout_err <= 1'b1;
         if ((m0_read && m0_write) || (m1_read && m1_write))
            proto_err <= 1'b1;
         case (state)
            // on a tie the master that was not served last wins
            IDLE: if (req0 && (!req1 || last)) state <= GNT0;
                  else if (req1) state <= GNT1;
            // the owner's request in its completion cycle belongs to the finished
            // transfer, so only the other master can take the bus directly
            GNT0: if (!req0) state <= IDLE;
                  else if (!s_waitrequest) begin
                     last  <= 1'b0;
                     state <= req1 ? GNT1 : IDLE;
                  end
            GNT1: if (!req1) state <= IDLE;
                  else if (!s_waitrequest) begin
                     last  <= 1'b1;
                     state <= req0 ? GNT0 : IDLE;
                  end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
